alu_seq_flags: RTL and testbench
================================

// Module: alu_seq_flags
//
// PURPOSE
// Parametrised, handshaked ALU with a persistent NZCV flag register.
// Accepts one operation at a time on a valid/ready input channel and holds the result on a valid/ready output channel.
// Single-cycle ops take 1 cycle; MUL is an iterative shift-add over WIDTH cycles.
// Sits between the operand/decode stage and writeback. Flags are held for later conditional logic.
//
// PARAMETERS
// WIDTH  8  operand/result width in bits, >=2, power of two (SHL amount = b[$clog2(WIDTH)-1:0])
//
// PORTS
// clk        in   1      single clock, rising edge
// rst_n      in   1      asynchronous active-low reset
// in_valid   in   1      operation presented
// in_ready   out  1      block can accept; high only in IDLE
// op         in   3      alu_pkg::op_t: ADD,SUB,AND,OR,XOR,SHL,MUL,CMP
// a, b       in   WIDTH  operands (unsigned/two's complement)
// set_flags  in   1      commit NZCV of this op to flag register
// out_valid  out  1      result held valid; high only in DONE
// out_ready  in   1      consumer accepts result
// result     out  WIDTH  op result (CMP: a-b)
// flags      out  4      registered {N,Z,C,V}
//
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, result=0, flags=4'b0000, out_valid=0, in_ready=1 after release.
//   Reset mid-MUL aborts the op; nothing is committed.
// - Handshakes: input accepted when in_valid&&in_ready; output retired when out_valid&&out_ready.
//   op/a/b/set_flags are captured at accept and are don't-care afterwards.
// - FSM IDLE->DONE: on accept of a non-MUL op; result and flags latched at that edge.
//   out_valid=1 the next cycle (latency 1).
// - FSM IDLE->BUSY: on accept of MUL; counter=0.
//   BUSY->DONE after WIDTH iterations (counter==WIDTH-1). out_valid asserts WIDTH+1 cycles after accept.
// - FSM DONE->IDLE: on out_ready. No combinational in_ready<-out_ready path.
//   Back-to-back single-cycle ops therefore sustain one op per 2 cycles.
// - DONE holds result/out_valid stable indefinitely while out_ready=0.
// - Arithmetic: ADD and SUB share one adder, s = a + (sub ? ~b : b) + sub, carry-out c.
//   ADD/SUB/CMP: C=c (SUB: C=1 means no borrow, a>=b unsigned).
//   V=(a[MSB]~^bx[MSB])&(s[MSB]^a[MSB]), where bx is the adder's B input.
// - AND/OR/XOR: C=0, V=0.
// - SHL by k=b[$clog2(WIDTH)-1:0]: result=a<<k; C=a[WIDTH-k] for k>0, else 0; V=0.
// - MUL: unsigned WIDTHxWIDTH; result=low WIDTH bits; C=1 iff high half !=0; V=0.
//   Internal 2*WIDTH accumulator.
// - All ops: N=result[WIDTH-1], Z=(result==0).
// - flags register updates only on the edge entering DONE, and only if the captured set_flags=1; otherwise it holds.
//   CMP with set_flags=0 therefore changes nothing visible except result.
// - result is held until the next commit; it is not cleared on retire.
//
// STRUCTURE
// - alu_pkg: op_t enum (ADD=0,SUB=1,AND=2,OR=3,XOR=4,SHL=5,MUL=6,CMP=7), state_t {IDLE,BUSY,DONE},
//   flag bit indices FLAG_N=3,FLAG_Z=2,FLAG_C=1,FLAG_V=0.
// - Sub-module alu_core #(WIDTH): combinational single-cycle ops + NZCV generation.
// - The top holds FSM, MUL iterator, operand/result/flag registers.
//
// TESTING (WIDTH=8)
// 1. ADD a=8'h7F b=8'h01 set_flags=1 -> result=8'h80, flags N1 Z0 C0 V1, out_valid 1 cycle after accept.
// 2. SUB a=8'h05 b=8'h05 set=1 -> result=0, N0 Z1 C1 V0; then CMP 8'h03,8'h05 set=0 -> result=8'hFE, flags unchanged.
// 3. MUL a=8'h10 b=8'h20 set=1 -> result=8'h00, Z1 C1, out_valid exactly 9 cycles after accept; in_ready=0 throughout.
// 4. SHL a=8'hC1 b=8'h01 -> result=8'h82, C1; b=8'h08 (k=0) -> result=8'hC1, C0.
// 5. Backpressure: out_ready=0 for 5 cycles after ADD -> result/out_valid stable, in_ready=0; new in_valid ignored.
// 6. rst_n pulsed low at MUL cycle 4 -> out_valid=0, flags=0, result=0 immediately; next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: opcodes, FSM states and flag bit positions.
`timescale 1ns/1ps
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_MUL = 3'd6,
        OP_CMP = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // CMP is a subtract whose only side effects are result and (optionally) flags.
    function automatic logic is_sub(input op_t op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU operations with NZCV generation.
// MUL is not handled here; the top iterates it and builds its own flags.
`timescale 1ns/1ps
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SW = $clog2(WIDTH);

    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl_wide;
    logic [SW-1:0]    shamt;
    logic             c;
    logic             v;

    always_comb begin
        sub      = is_sub(op);
        bx       = sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
        shamt    = b[SW-1:0];
        // The bit shifted out past the MSB lands in shl_wide[WIDTH]; zero when shamt==0.
        shl_wide = {1'b0, a} << shamt;

        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_CMP: begin
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = (a[WIDTH-1] ~^ bx[WIDTH-1]) & (sum[WIDTH-1] ^ a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = shl_wide[WIDTH-1:0];
                c      = shl_wide[WIDTH];
            end
            default: result = '0;
        endcase

        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/alu_seq_flags.sv
// Handshaked ALU: IDLE/BUSY/DONE sequencer, iterative shift-add multiplier,
// and the result / NZCV registers that persist between operations.
`timescale 1ns/1ps
module alu_seq_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    // state   | meaning
    // IDLE    | waiting for an operation, in_ready=1
    // BUSY    | MUL iterating, one partial product per cycle
    // DONE    | result held, out_valid=1 until out_ready

    localparam int CW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic               accept;
    logic               load;
    logic               mul_last;

    logic [WIDTH-1:0]   core_result;
    logic [3:0]         core_flags;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [CW-1:0]      cnt_q;
    logic               set_q;

    logic [WIDTH-1:0]   commit_result;
    logic [3:0]         commit_flags;
    logic               commit_set;

    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flags_q;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (core_result),
        .flags  (core_flags)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign mul_last  = (state_q == ST_BUSY) && (cnt_q == CW'(WIDTH - 1));
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign result    = result_q;
    assign flags     = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        commit_result = core_result;
        commit_flags  = core_flags;
        commit_set    = set_flags;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_DONE;
                        load    = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                commit_result         = acc_step[WIDTH-1:0];
                commit_flags          = '0;
                commit_flags[FLAG_N]  = acc_step[WIDTH-1];
                commit_flags[FLAG_Z]  = (acc_step[WIDTH-1:0] == '0);
                commit_flags[FLAG_C]  = |acc_step[2*WIDTH-1:WIDTH];
                commit_set            = set_q;
                if (mul_last) begin
                    state_d = ST_DONE;
                    load    = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Multiplicand walks left while the multiplier walks right, so bit 0 of
    // mplier_q always selects whether the current shifted multiplicand is added.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            set_q    <= 1'b0;
        end else if (accept && (op == OP_MUL)) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            set_q    <= set_flags;
        end else if (state_q == ST_BUSY) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_step;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= 4'b0000;
        end else if (load) begin
            result_q <= commit_result;
            if (commit_set) begin
                flags_q <= commit_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_flags.sv
// Scoreboard bench for alu_seq_flags: directed corner cases then random ops
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq_flags;
    import alu_pkg::*;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    op_t          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         set_flags;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    alu_seq_flags #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .set_flags (set_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int flg;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   model_flags = 0;
    bit   pending = 0;
    bit   seen = 0;
    bit   bp_hold = 0;
    bit   rand_ready = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bp_hold) out_ready = 1'b0;
        else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Reference model: plain integer arithmetic on the operand values.
    task automatic model(input op_t o, input int x, input int y, input bit s, output exp_t e);
        int full;
        int sr;
        int k;
        int c;
        int v;
        int r;
        c = 0;
        v = 0;
        r = 0;
        case (o)
            OP_ADD: begin
                full = x + y;
                r = full % M;
                c = (full >= M) ? 1 : 0;
                sr = sx(x) + sx(y);
                v = (sr > M / 2 - 1 || sr < -(M / 2)) ? 1 : 0;
            end
            OP_SUB, OP_CMP: begin
                r = (x - y + M) % M;
                c = (x >= y) ? 1 : 0;
                sr = sx(x) - sx(y);
                v = (sr > M / 2 - 1 || sr < -(M / 2)) ? 1 : 0;
            end
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_XOR: r = x ^ y;
            OP_SHL: begin
                k = y % W;
                r = (x << k) % M;
                c = (k > 0) ? ((x >> (W - k)) & 1) : 0;
            end
            default: begin
                full = x * y;
                r = full % M;
                c = (full >= M) ? 1 : 0;
            end
        endcase
        if (s) model_flags = ((r >= M / 2) ? 8 : 0) + ((r == 0) ? 4 : 0) + c * 2 + v;
        e.res = r;
        e.flg = model_flags;
        e.lat = (o == OP_MUL) ? W + 1 : 1;
        e.acc = 0;
    endtask

    task automatic issue(input op_t o, input int x, input int y, input bit s);
        exp_t e;
        int n;
        op = o;
        a = W'(x);
        b = W'(y);
        set_flags = s;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model(o, x, y, s, e);
            e.acc = cyc;
            sb.push_back(e);
            pending = 1'b1;
            in_valid = 1'b0;
            op = op_t'($urandom_range(0, 7));
            a = W'($urandom);
            b = W'($urandom);
            set_flags = 1'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
        #1;
    endtask

    // Monitor: latency on first out_valid, result/flags at retirement.
    always @(negedge clk) begin
        exp_t it;
        if (rst_n) begin
            if (out_valid) begin
                chk("in_ready_in_done", int'(in_ready), 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output actual=valid required=none");
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        pending = 1'b0;
                        chk("latency", cyc - sb[0].acc + 1, sb[0].lat);
                    end
                    if (out_ready) begin
                        it = sb.pop_front();
                        chk("result", int'(result), it.res);
                        chk("flags", int'(flags), it.flg);
                        seen = 1'b0;
                    end
                end
            end else if (pending) begin
                chk("in_ready_in_busy", int'(in_ready), 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        op = OP_ADD;
        a = '0;
        b = '0;
        set_flags = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", int'(result), 0);
        chk("reset_flags", int'(flags), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        issue(OP_ADD, 'h7F, 'h01, 1'b1);
        issue(OP_SUB, 'h05, 'h05, 1'b1);
        issue(OP_CMP, 'h03, 'h05, 1'b0);
        issue(OP_MUL, 'h10, 'h20, 1'b1);
        issue(OP_SHL, 'hC1, 'h01, 1'b1);
        issue(OP_SHL, 'hC1, 'h08, 1'b1);
        issue(OP_MUL, 'hFF, 'hFF, 1'b1);
        issue(OP_SUB, 'h80, 'h01, 1'b1);
        drain();

        // Backpressure: result and out_valid held while a second op is offered.
        @(negedge clk);
        bp_hold = 1'b1;
        @(posedge clk);
        #1;
        issue(OP_ADD, 'h22, 'h33, 1'b1);
        op = OP_SUB;
        a = 8'hAA;
        b = 8'h11;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result", int'(result), 'h55);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        bp_hold = 1'b0;
        drain();

        // Reset in the middle of a MUL.
        issue(OP_SUB, 'h00, 'h01, 1'b1);
        drain();
        op = OP_MUL;
        a = 8'h03;
        b = 8'h05;
        set_flags = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midmul_out_valid", int'(out_valid), 0);
        chk("midmul_flags", int'(flags), 0);
        chk("midmul_result", int'(result), 0);
        model_flags = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midmul_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        issue(OP_ADD, 'h12, 'h34, 1'b1);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            issue(op_t'($urandom_range(0, 7)), int'($urandom_range(0, M - 1)),
                  int'($urandom_range(0, M - 1)), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
